// File: rtl/mp_mul_pkg.sv
// Shared FSM state type plus sizing and latency helpers for the mp_mul_seq multiplier.
package mp_mul_pkg;

    typedef enum logic [1:0] {IDLE, MUL, ROWEND, DONE} state_t;

    // Counter width for an index over `words` entries; never narrower than 1 bit.
    function automatic int unsigned mp_cnt_w(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Cycles from the accepted-start cycle to the done cycle, fixed-schedule build.
    function automatic int unsigned mp_latency(input int unsigned words);
        return words * (words + 1) + 1;
    endfunction

    // Same, zero-row-skip build: one lead cycle, one cycle per zero row, WORDS+1 otherwise.
    function automatic int unsigned mp_latency_skip(input int unsigned words,
                                                    input int unsigned zero_rows);
        return 2 + zero_rows + (words - zero_rows) * (words + 1);
    endfunction

endpackage

// File: rtl/mp_mac_word.sv
// One W x W multiply-accumulate word step: {hi,lo} = x*y + acc_in + c_in (never overflows 2W bits).
module mp_mac_word #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] acc_in,
    input  logic [W-1:0] c_in,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic [2*W-1:0] sum;

    always_comb begin
        sum = (2*W)'(x) * (2*W)'(y) + (2*W)'(acc_in) + (2*W)'(c_in);
        lo  = sum[W-1:0];
        hi  = sum[2*W-1:W];
    end

endmodule

// File: rtl/mp_mul_seq.sv
// Sequential operand-scanning multi-precision multiplier, one W x W MAC per cycle.
// Optional build macro MP_MUL_ZERO_SKIP_EN skips the MUL pass of rows whose a word is zero.
module mp_mul_seq
    import mp_mul_pkg::*;
#(
    parameter int unsigned WORDS = 32,
    parameter int unsigned W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a       [0:WORDS-1],
    input  logic [W-1:0] b       [0:WORDS-1],
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product [0:2*WORDS-1]
);

    localparam int unsigned CW = mp_cnt_w(WORDS);
    localparam int unsigned AW = mp_cnt_w(2 * WORDS);

    state_t         state_q, state_d;
    logic [W-1:0]   a_r_q  [0:WORDS-1];
    logic [W-1:0]   a_r_d  [0:WORDS-1];
    logic [W-1:0]   b_r_q  [0:WORDS-1];
    logic [W-1:0]   b_r_d  [0:WORDS-1];
    logic [W-1:0]   acc_q  [0:2*WORDS-1];
    logic [W-1:0]   acc_d  [0:2*WORDS-1];
    logic [W-1:0]   prod_q [0:2*WORDS-1];
    logic [W-1:0]   prod_d [0:2*WORDS-1];
    logic [CW-1:0]  i_q, i_d, j_q, j_d, i_nxt;
    logic [W-1:0]   carry_q, carry_d;
    logic [AW-1:0]  ij, iw;
    logic [W-1:0]   mac_lo, mac_hi;
`ifdef MP_MUL_ZERO_SKIP_EN
    logic           lead_q, lead_d;
`endif

    assign ij      = AW'(i_q) + AW'(j_q);
    assign iw      = AW'(i_q) + AW'(WORDS);
    assign i_nxt   = i_q + CW'(1);
    assign product = prod_q;

    mp_mac_word #(.W(W)) u_mac (
        .x      (a_r_q[i_q]),
        .y      (b_r_q[j_q]),
        .acc_in (acc_q[ij]),
        .c_in   (carry_q),
        .lo     (mac_lo),
        .hi     (mac_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_r_q   <= '{default: '0};
            b_r_q   <= '{default: '0};
            acc_q   <= '{default: '0};
            prod_q  <= '{default: '0};
            i_q     <= '0;
            j_q     <= '0;
            carry_q <= '0;
`ifdef MP_MUL_ZERO_SKIP_EN
            lead_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_r_q   <= a_r_d;
            b_r_q   <= b_r_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            i_q     <= i_d;
            j_q     <= j_d;
            carry_q <= carry_d;
`ifdef MP_MUL_ZERO_SKIP_EN
            lead_q  <= lead_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_r_d   = a_r_q;
        b_r_d   = b_r_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        i_d     = i_q;
        j_d     = j_q;
        carry_d = carry_q;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef MP_MUL_ZERO_SKIP_EN
        lead_d  = lead_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_r_d   = a;
                    b_r_d   = b;
                    acc_d   = '{default: '0};
                    i_d     = '0;
                    j_d     = '0;
                    carry_d = '0;
`ifdef MP_MUL_ZERO_SKIP_EN
                    // A lead ROWEND pass tests row 0 from the captured register, not the raw port.
                    lead_d  = 1'b1;
                    state_d = ROWEND;
`else
                    state_d = MUL;
`endif
                end
            end
            MUL: begin
                busy       = 1'b1;
                acc_d[ij]  = mac_lo;
                carry_d    = mac_hi;
                if (j_q == CW'(WORDS - 1)) state_d = ROWEND;
                else                       j_d     = j_q + CW'(1);
            end
            ROWEND: begin
                busy = 1'b1;
`ifdef MP_MUL_ZERO_SKIP_EN
                if (lead_q) begin
                    lead_d  = 1'b0;
                    state_d = (a_r_q[0] == '0) ? ROWEND : MUL;
                end else
`endif
                begin
                    acc_d[iw] = carry_q;
                    carry_d   = '0;
                    j_d       = '0;
                    // Product is latched here so it is already valid during the DONE cycle.
                    if (i_q == CW'(WORDS - 1)) begin
                        state_d = DONE;
                        prod_d  = acc_d;
                    end else begin
                        i_d     = i_nxt;
                        state_d = MUL;
`ifdef MP_MUL_ZERO_SKIP_EN
                        if (a_r_q[i_nxt] == '0) state_d = ROWEND;
`endif
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mp_mul_seq.sv
// Scoreboard bench for mp_mul_seq over several WORDS/W shapes, checked against a wide-integer product.
`timescale 1ns/1ps
module tb_mp_mul_seq;
    import mp_mul_pkg::*;

    localparam int NCFG = 8;

    function automatic int cfg_words(input int k);
        case (k)
            0: return 2;   1: return 32;  2: return 1;  3: return 3;
            4: return 8;   5: return 3;   6: return 1;  default: return 4;
        endcase
    endfunction

    function automatic int cfg_width(input int k);
        case (k)
            0: return 16;  1: return 16;  2: return 8;  3: return 16;
            4: return 32;  5: return 8;   6: return 32; default: return 16;
        endcase
    endfunction

    function automatic int cfg_nrand(input int k);
        case (k)
            0: return 15;  1: return 2;   2: return 30; 3: return 30;
            4: return 20;  5: return 30;  6: return 30; default: return 25;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int nfin   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    for (genvar k = 0; k < NCFG; k++) begin : g
        localparam int WD     = cfg_words(k);
        localparam int WW     = cfg_width(k);
        localparam int NB     = WD * WW;
        localparam int LATMAX = WD * (WD + 1) + 2;

        logic          rst_n, start, busy, done;
        logic [WW-1:0] a_s  [0:WD-1];
        logic [WW-1:0] b_s  [0:WD-1];
        logic [WW-1:0] prod [0:2*WD-1];

        logic [2*NB-1:0] exp_q [$];
        int              c0_q  [$];
        int              lat_q [$];

        mp_mul_seq #(.WORDS(WD), .W(WW)) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start),
            .a       (a_s),
            .b       (b_s),
            .busy    (busy),
            .done    (done),
            .product (prod)
        );

        // Whole-operand integer product of the current operand ports.
        function automatic logic [2*NB-1:0] ref_mul();
            logic [2*NB-1:0] x = '0;
            logic [2*NB-1:0] y = '0;
            for (int i = 0; i < WD; i++) begin
                x[i*WW +: WW] = a_s[i];
                y[i*WW +: WW] = b_s[i];
            end
            return x * y;
        endfunction

        function automatic int exp_lat();
`ifdef MP_MUL_ZERO_SKIP_EN
            int z = 0;
            for (int i = 0; i < WD; i++) if (a_s[i] == '0) z++;
            return int'(mp_latency_skip(WD, z));
`else
            return int'(mp_latency(WD));
`endif
        endfunction

        task automatic push_op(input int c0);
            exp_q.push_back(ref_mul());
            c0_q.push_back(c0);
            lat_q.push_back(exp_lat());
        endtask

        task automatic rand_ops(input bit sparse);
            for (int i = 0; i < WD; i++) begin
                a_s[i] = WW'($urandom);
                b_s[i] = WW'($urandom);
                if (sparse && $urandom_range(3) == 0) a_s[i] = '0;
            end
        endtask

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic issue();
            start = 1'b1;
            push_op(cyc);
            step();
            start = 1'b0;
        endtask

        task automatic step_idle(input string tag);
            step();
            check($sformatf("k%0d %s idle_busy", k, tag), 64'(busy), 64'(0));
            check($sformatf("k%0d %s idle_done", k, tag), 64'(done), 64'(0));
        endtask

        task automatic check_quiet(input string tag);
            logic [WW-1:0] o = '0;
            for (int w = 0; w < 2 * WD; w++) o |= prod[w];
            check($sformatf("k%0d %s busy", k, tag), 64'(busy), 64'(0));
            check($sformatf("k%0d %s done", k, tag), 64'(done), 64'(0));
            check($sformatf("k%0d %s product_or", k, tag), 64'(o), 64'(0));
        endtask

        // Leaves the caller in the done cycle; operands are scrambled while waiting.
        task automatic wait_done(input string tag);
            bit seen = 1'b0;
            for (int n = 0; n < LATMAX + 8; n++) begin
                if (done === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                rand_ops(1'b0);
                step();
            end
            check($sformatf("k%0d %s done_seen", k, tag), 64'(seen), 64'(1));
        endtask

        initial begin : mon
            logic [2*NB-1:0] e;
            int c0, l, bad;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("k%0d spurious_done queue_depth", k), 64'(exp_q.size()), 64'(1));
                    end else begin
                        e   = exp_q.pop_front();
                        c0  = c0_q.pop_front();
                        l   = lat_q.pop_front();
                        bad = 0;
                        for (int w = 2 * WD - 1; w >= 0; w--)
                            if (prod[w] !== e[w*WW +: WW]) bad = w;
                        check($sformatf("k%0d product[%0d]", k, bad), 64'(prod[bad]), 64'(e[bad*WW +: WW]));
                        check($sformatf("k%0d latency", k), 64'(cyc - c0), 64'(l));
                    end
                end
            end
        end

        initial begin : stim
            bit chain;
            int lat, s2, r;
            rst_n = 1'b0;
            start = 1'b0;
            for (int i = 0; i < WD; i++) begin
                a_s[i] = '0;
                b_s[i] = '0;
            end
            repeat (3) step();
            check_quiet("in_reset");
            rst_n = 1'b1;
            step();
            check_quiet("post_reset");

            // All-ones operands with the busy/done timeline checked cycle by cycle.
            for (int i = 0; i < WD; i++) begin
                a_s[i] = '1;
                b_s[i] = '1;
            end
            lat = exp_lat();
            issue();
            for (int n = 1; n <= lat; n++) begin
                check($sformatf("k%0d ones busy@%0d", k, n), 64'(busy), 64'(n < lat));
                check($sformatf("k%0d ones done@%0d", k, n), 64'(done), 64'(n == lat));
                if (n < lat) step();
            end
            step_idle("ones");

            // a = 1 returns b unchanged in the low half.
            for (int i = 0; i < WD; i++) begin
                a_s[i] = '0;
                b_s[i] = WW'($urandom);
            end
            a_s[0] = WW'(1);
            issue();
            wait_done("a_one");
            step_idle("a_one");

            // Single non-zero word in position 1: a shifted multiple of b.
            for (int i = 0; i < WD; i++) begin
                a_s[i] = '0;
                b_s[i] = WW'($urandom);
            end
            a_s[(WD > 1) ? 1 : 0] = WW'(5);
            issue();
            wait_done("sparse");
            step_idle("sparse");

            // Second start while busy must be dropped, not queued.
            rand_ops(1'b1);
            lat = exp_lat();
            s2  = (lat > 6) ? 5 : lat - 1;
            issue();
            repeat (s2 - 1) step();
            rand_ops(1'b0);
            start = 1'b1;
            step();
            start = 1'b0;
            wait_done("busy_start");
            step_idle("busy_start");

            // Reset in the middle of a run discards it.
            rand_ops(1'b1);
            lat = exp_lat();
            r   = (lat > 21) ? 20 : lat - 1;
            issue();
            repeat (r - 1) step();
            rst_n = 1'b0;
            #1;
            exp_q.delete();
            c0_q.delete();
            lat_q.delete();
            check_quiet("mid_reset");
            step();
            rst_n = 1'b1;
            step();
            check_quiet("after_mid_reset");

            // Random regression; a start held high across done is taken the cycle after.
            chain = 1'b0;
            for (int n = 0; n < cfg_nrand(k); n++) begin
                rand_ops(1'b1);
                start = 1'b1;
                if (chain) begin
                    push_op(cyc + 1);
                    step();
                    step();
                end else begin
                    push_op(cyc);
                    step();
                end
                start = 1'b0;
                wait_done("rand");
                chain = ($urandom_range(1) == 1);
                if (!chain) step_idle("rand");
            end
            if (chain) step_idle("rand_last");
            @(negedge clk);
            #1;
            check($sformatf("k%0d queue_drained", k), 64'(exp_q.size()), 64'(0));
            nfin++;
        end
    end

    initial begin : ctrl
        int n = 0;
        while (nfin < NCFG && n < 30000) begin
            @(posedge clk);
            n++;
        end
        check("all_configs_finished", 64'(nfin), 64'(NCFG));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
